// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampled UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } uart_state_t;

  // Clocks per oversampling tick; truncating division.
  function automatic int calc_div(input int clk_freq, input int baud_rate, input int os);
    return clk_freq / (baud_rate * os);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Oversampling tick generator: free-running 0..DIV-1 counter, tick on the last count,
// with a synchronous clear to re-phase it onto a line edge.
module uart_os_tick #(
  parameter int DIV = 13
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver with false-start and framing-error detection.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600,
  parameter int OS        = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       done,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int DIV = calc_div(clk_freq, baud_rate, OS);
  localparam int TW  = $clog2(OS);
  localparam logic [TW-1:0] HALF_T = TW'(OS / 2 - 1);
  localparam logic [TW-1:0] LAST_T = TW'(OS - 1);

  uart_state_t r_state;
  logic          r_rx_meta;
  logic          r_rx_s;
  logic          r_rx_prev;
  logic [TW-1:0] r_tick_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_dout;
  logic          r_done;
  logic          r_frame_err;
  logic          w_fall;
  logic          w_clr;
  logic          w_tick;
`ifdef UART_RX_PARITY_EN
  logic          r_par_bit;
  logic          r_parity_err;
`endif

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  assign w_fall = r_rx_prev & ~r_rx_s;
  assign w_clr  = (r_state == IDLE) & w_fall;

  uart_os_tick #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_tick_cnt  <= '0;
      r_bit_idx   <= '0;
      r_dout      <= 8'h00;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_state    <= START;
            r_tick_cnt <= '0;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_tick_cnt == HALF_T) begin
              r_tick_cnt <= '0;
              r_bit_idx  <= '0;
              // Line back high at the start-bit centre: treat as a glitch.
              r_state    <= r_rx_s ? IDLE : DATA;
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            if (r_tick_cnt == LAST_T) begin
              r_tick_cnt          <= '0;
              r_shift[r_bit_idx]  <= r_rx_s;
              r_bit_idx           <= r_bit_idx + 3'd1;
              if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                r_state <= PARITY;
`else
                r_state <= STOP;
`endif
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            if (r_tick_cnt == LAST_T) begin
              r_tick_cnt <= '0;
              r_par_bit  <= r_rx_s;
              r_state    <= STOP;
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end
`endif
        STOP: begin
          if (w_tick) begin
            if (r_tick_cnt == LAST_T) begin
              r_tick_cnt <= '0;
              r_dout     <= r_shift;
              if (r_rx_s) begin
                r_done  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                r_parity_err <= ^r_shift ^ r_par_bit;
`endif
                r_state <= IDLE;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= WAIT_IDLE;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + TW'(1);
            end
          end
        end
        WAIT_IDLE: begin
          // Hold off through a break until the line returns to idle.
          if (r_rx_s) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dout      = r_dout;
  assign done      = r_done;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at defaults (104 clk per bit); vector table plus corner sequences.
`timescale 1ns/1ps
module tb_uart_rx_os;

  localparam int BIT = 104;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] dout;
  logic       done;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int n_done = 0;
  int n_ferr = 0;
  int n_perr = 0;
  int s_done, s_ferr, s_perr;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       par_flip;
    int         gap;
    int         exp_done;
    int         exp_ferr;
    int         exp_perr;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[$];

  uart_rx_os #(.clk_freq(1000000), .baud_rate(9600), .OS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .dout       (dout),
    .done       (done),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Count every high cycle so a stuck or stretched pulse shows up as an extra count.
  always @(negedge clk) begin
    if (done)       n_done++;
    if (frame_err)  n_ferr++;
    if (parity_err) n_perr++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic snap();
    s_done = n_done;
    s_ferr = n_ferr;
    s_perr = n_perr;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_body(input logic [7:0] d, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`else
    if (par_flip) rx = 1'b1;
`endif
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    send_body(d, par_flip);
    send_bit(stop);
    rx = 1'b1;
  endtask

  initial begin
    vecs.push_back('{8'hA5, 1'b1, 1'b0, 200, 1, 0, 0, 8'hA5});
    vecs.push_back('{8'h3C, 1'b1, 1'b0,   0, 1, 0, 0, 8'h3C});
    vecs.push_back('{8'hC3, 1'b1, 1'b0, 200, 1, 0, 0, 8'hC3});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h07, 1'b1, 1'b1, 200, 1, 0, 1, 8'h07});
    vecs.push_back('{8'h07, 1'b1, 1'b0, 200, 1, 0, 0, 8'h07});
`endif

    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_dout", dout, 8'h00);
    chk("reset_done", done, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_parity_err", parity_err, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Table: normal frames, rows with gap 0 run back-to-back into the next.
    for (int v = 0; v < vecs.size(); v++) begin
      snap();
      send_frame(vecs[v].data, vecs[v].stop, vecs[v].par_flip);
      chk($sformatf("vec%0d_busy_end", v), busy, 0);
      repeat (vecs[v].gap) @(negedge clk);
      chk($sformatf("vec%0d_done", v), n_done - s_done, vecs[v].exp_done);
      chk($sformatf("vec%0d_frame_err", v), n_ferr - s_ferr, vecs[v].exp_ferr);
      chk($sformatf("vec%0d_parity_err", v), n_perr - s_perr, vecs[v].exp_perr);
      chk($sformatf("vec%0d_dout", v), dout, vecs[v].exp_dout);
    end

    // Short low glitch on an idle line.
    snap();
    rx = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_busy_mid", busy, 1);
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_done", n_done - s_done, 0);
    chk("glitch_frame_err", n_ferr - s_ferr, 0);
    chk("glitch_busy_after", busy, 0);
    chk("glitch_dout_kept", dout, 8'hC3);

    // Stop bit low followed by a long break.
    snap();
    send_body(8'h55, 1'b0);
    rx = 1'b0;
    repeat (BIT + 300) @(negedge clk);
    chk("break_busy_hold", busy, 1);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    chk("break_frame_err", n_ferr - s_ferr, 1);
    chk("break_done", n_done - s_done, 0);
    chk("break_parity_err", n_perr - s_perr, 0);
    chk("break_dout", dout, 8'h55);
    chk("break_busy_after", busy, 0);
    snap();
    send_frame(8'h01, 1'b1, 1'b0);
    repeat (200) @(negedge clk);
    chk("recover_done", n_done - s_done, 1);
    chk("recover_frame_err", n_ferr - s_ferr, 0);
    chk("recover_dout", dout, 8'h01);

    // Reset at data bit 4 of 0xFF; the rest of that frame is all ones.
    snap();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_dout_reset", dout, 8'h00);
    repeat (6 * BIT) @(negedge clk);
    chk("abort_done", n_done - s_done, 0);
    chk("abort_frame_err", n_ferr - s_ferr, 0);
    chk("abort_dout_kept", dout, 8'h00);
    snap();
    send_frame(8'h12, 1'b1, 1'b0);
    repeat (200) @(negedge clk);
    chk("after_abort_done", n_done - s_done, 1);
    chk("after_abort_dout", dout, 8'h12);
    chk("after_abort_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
